// File: rtl/cordic_pre_rotate.sv
// Two-stage front end for a rotation-mode CORDIC: folds the target angle into [-90,90]
// and hands the downstream stage its starting vector (Vx=K, Vy=0) plus a result-negate flag.
module cordic_pre_rotate #(
    parameter logic signed [18:0] X_INIT = 19'sd79594
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [8:0]  angle_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [18:0] Vx,
    output logic signed [18:0] Vy,
    output logic signed [8:0]  Z,
    output logic signed [2:0]  i,
    output logic               flip
);

    // Returns {flip, folded angle}. Angles beyond +/-90 are mirrored by 180 degrees,
    // which negates the rotated vector, so the downstream result must be flipped.
    function automatic logic [9:0] fold_angle(input logic signed [8:0] a);
        logic signed [9:0] a10;
        logic signed [9:0] r10;
        logic              f;
        a10 = {a[8], a};
        if (a10 > 10'sd90) begin
            r10 = a10 - 10'sd180;
            f   = 1'b1;
        end else if (a10 < -10'sd90) begin
            r10 = a10 + 10'sd180;
            f   = 1'b1;
        end else begin
            r10 = a10;
            f   = 1'b0;
        end
        return {f, r10[8:0]};
    endfunction

    logic              r_s1_valid;
    logic signed [8:0] r_s1_z;
    logic              r_s1_flip;
    logic              r_out_valid;
    logic signed [8:0] r_z;
    logic              r_flip;

    logic              w_s2_free;
    logic              w_s1_load;
    logic              w_s1_move;
    logic [9:0]        w_fold;

    assign w_s2_free = !r_out_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_free;
    assign w_s1_load = in_valid && in_ready;
    assign w_s1_move = r_s1_valid && w_s2_free;
    assign w_fold    = fold_angle(angle_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_z      <= '0;
            r_s1_flip   <= 1'b0;
            r_out_valid <= 1'b0;
            r_z         <= '0;
            r_flip      <= 1'b0;
        end else begin
            // S2: output register, advances only when downstream can take it
            if (w_s2_free) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_z    <= r_s1_z;
                    r_flip <= r_s1_flip;
                end
            end
            // S1: folded angle; a new sample may enter on the same edge S1 drains
            if (w_s1_load) begin
                r_s1_valid <= 1'b1;
                r_s1_z     <= signed'(w_fold[8:0]);
                r_s1_flip  <= w_fold[9];
            end else if (w_s1_move) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign Z         = r_z;
    assign flip      = r_flip;
    assign Vx        = X_INIT;
    assign Vy        = '0;
    assign i         = '0;

endmodule

// File: tb/tb_cordic_pre_rotate.sv
// Bench for cordic_pre_rotate: directed scenarios plus a randomized handshake run,
// scored against a queue-based angle-fold model.
module tb_cordic_pre_rotate;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [8:0]  angle_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [18:0] Vx;
    logic signed [18:0] Vy;
    logic signed [8:0]  Z;
    logic signed [2:0]  i;
    logic               flip;

    cordic_pre_rotate dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .angle_in(angle_in), .out_valid(out_valid), .out_ready(out_ready),
        .Vx(Vx), .Vy(Vy), .Z(Z), .i(i), .flip(flip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_out = 0;
    int qz[$];
    int qf[$];
    bit hold_prev = 1'b0;
    int held_z;
    int held_f;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference fold: bring any angle into [-90,90] by a half-turn, noting the negation.
    function automatic int fold_ref(input int a, output int f);
        if (a > 90) begin
            f = 1;
            return a - 180;
        end
        if (a < -90) begin
            f = 1;
            return a + 180;
        end
        f = 0;
        return a;
    endfunction

    // Scoreboard and stall-stability monitor, sampled mid-cycle ahead of the next edge.
    always @(negedge clk) begin
        int ez;
        int ef;
        if (hold_prev) begin
            check_val("hold_out_valid", int'(out_valid), 1);
            check_val("hold_z", int'(Z), held_z);
            check_val("hold_flip", int'(flip), held_f);
        end
        hold_prev = out_valid && !out_ready && !rst;
        held_z    = int'(Z);
        held_f    = int'(flip);
        if (rst) begin
            qz.delete();
            qf.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (qz.size() == 0) begin
                    check_val("unexpected_output_qsize", qz.size(), 1);
                end else begin
                    ez = qz.pop_front();
                    ef = qf.pop_front();
                    check_val("out_z", int'(Z), ez);
                    check_val("out_flip", int'(flip), ef);
                    check_val("out_vx", int'(Vx), 79594);
                    check_val("out_vy", int'(Vy), 0);
                    check_val("out_i", int'(i), 0);
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                ez = fold_ref(int'(angle_in), ef);
                qz.push_back(ez);
                qf.push_back(ef);
                n_acc++;
            end
        end
    end

    task automatic send_one(input int a);
        bit acc;
        int t;
        acc      = 1'b0;
        t        = 0;
        in_valid = 1'b1;
        angle_in = 9'(a);
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 50);
        in_valid = 1'b0;
        check_val("send_accepted", int'(acc), 1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stream_a[6] = '{120, -135, 90, -90, 255, -256};
        int stream_z[6] = '{-60, 45, 90, -90, 75, -76};
        int stream_f[6] = '{1, 1, 0, 0, 1, 1};
        int base;
        int t;
        int cyc;

        rst = 1'b1; in_valid = 1'b0; angle_in = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_out_valid", int'(out_valid), 0);
        check_val("rst_z", int'(Z), 0);
        check_val("rst_flip", int'(flip), 0);
        check_val("rst_vx", int'(Vx), 79594);
        check_val("rst_vy", int'(Vy), 0);
        check_val("rst_i", int'(i), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_in_ready", int'(in_ready), 1);

        // Single sample: two-cycle latency
        @(posedge clk); #1;
        in_valid = 1'b1; angle_in = 9'sd30;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_val("lat_out_valid_early", int'(out_valid), 0);
        @(negedge clk);
        check_val("lat_out_valid", int'(out_valid), 1);
        check_val("lat_z", int'(Z), 30);
        check_val("lat_flip", int'(flip), 0);
        repeat (2) @(posedge clk); #1;

        // Back-to-back boundary stream, no bubbles expected
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    in_valid = 1'b1; angle_in = 9'(stream_a[k]);
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                t = 0;
                @(negedge clk);
                while (!out_valid && t < 10) begin
                    @(negedge clk);
                    t++;
                end
                for (int k = 0; k < 6; k++) begin
                    check_val("stream_valid", int'(out_valid), 1);
                    check_val("stream_z", int'(Z), stream_z[k]);
                    check_val("stream_flip", int'(flip), stream_f[k]);
                    @(negedge clk);
                end
            end
        join
        repeat (3) @(posedge clk); #1;

        // Backpressure: two samples held, in_ready drops, then drain in order
        base = n_out;
        out_ready = 1'b0;
        fork
            begin
                for (int k = 1; k <= 4; k++) send_one(10 * k);
            end
            begin
                repeat (6) @(negedge clk);
                check_val("bp_in_ready", int'(in_ready), 0);
                check_val("bp_out_valid", int'(out_valid), 1);
                check_val("bp_z", int'(Z), 10);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk); #1;
        check_val("bp_delivered", n_out - base, 4);

        // Reset with samples in flight and a sample offered on the reset edge
        out_ready = 1'b0;
        send_one(11);
        send_one(22);
        in_valid = 1'b1; angle_in = 9'sd50; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check_val("mid_rst_out_valid", int'(out_valid), 0);
        check_val("mid_rst_in_ready", int'(in_ready), 1);
        send_one(60);
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 10) begin
            @(negedge clk);
            t++;
        end
        check_val("mid_rst_first_valid", int'(out_valid), 1);
        check_val("mid_rst_first_z", int'(Z), 60);
        repeat (3) @(posedge clk); #1;

        // Randomized handshakes on both sides
        base = n_acc;
        cyc  = 0;
        while ((n_acc - base) < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            angle_in  = 9'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
            cyc++;
        end
        check_val("rand_accepted_enough", int'((n_acc - base) >= 10000), 1);
        in_valid = 1'b0; out_ready = 1'b1;
        t = 0;
        while (qz.size() != 0 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        @(negedge clk);
        check_val("drain_queue_empty", qz.size(), 0);
        check_val("drain_out_valid", int'(out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
